frame_scheduler: RTL and testbench

// Per-frame sequencer for the pixel pipeline (gensync -> image_process -> position).

---
 rtl/frame_scheduler.sv | 163 ++++++++++++++++
 tb/tb_frame_scheduler.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_scheduler.sv
// Per-frame sequencer: frame boundary detection, accumulator clear/enable gating, result capture
// with a valid/ready output, and watchdog. Define FRAME_SCHED_OVERLAY_EN to build the overlay select toggle.
module frame_scheduler #(
  parameter int SKIP_FRAMES = 1,
  parameter int WD_CYCLES   = 500000,
  parameter int X_W         = 10,
  parameter int Y_W         = 9
) (
  input  logic           vga_clk,
  input  logic           reset,
  input  logic           vsync_i,
  input  logic           img_i,
  input  logic           mode_i,
  input  logic           start_i,
  input  logic           stop_i,
  input  logic [X_W-1:0] bary_x_i,
  input  logic [Y_W-1:0] bary_y_i,
  output logic           acc_clr_o,
  output logic           acc_en_o,
  output logic           sel_o,
  output logic           res_valid_o,
  input  logic           res_ready_i,
  output logic [X_W-1:0] res_x_o,
  output logic [Y_W-1:0] res_y_o,
  output logic [7:0]     res_frame_o,
  output logic [7:0]     drop_cnt_o,
  output logic           wd_err_o
);

  localparam int SKIP_W = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;
  localparam int WD_W   = $clog2(WD_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_ACCUM, S_LATCH} state_t;

  state_t            r_state;
  logic              r_vsync_d;
  logic [7:0]        r_frame;
  logic [SKIP_W-1:0] r_skip;
  logic [WD_W-1:0]   r_wd_cnt;
  logic              r_acc_clr;
  logic              r_res_valid;
  logic [X_W-1:0]    r_res_x;
  logic [Y_W-1:0]    r_res_y;
  logic [7:0]        r_res_frame;
  logic [7:0]        r_drop_cnt;
  logic              r_wd_err;

  logic w_fb;
  logic w_waiting;
  logic w_wd_hit;

  // Frame boundary is the cycle in which vsync is low after being high on the previous edge.
  assign w_fb      = r_vsync_d & ~vsync_i;
  assign w_waiting = (r_state == S_ARM) || (r_state == S_ACCUM);
  assign w_wd_hit  = w_waiting && !w_fb && (r_wd_cnt == WD_W'(WD_CYCLES - 1));

  assign acc_en_o    = (r_state == S_ACCUM) && img_i && !stop_i;
  assign acc_clr_o   = r_acc_clr;
  assign res_valid_o = r_res_valid;
  assign res_x_o     = r_res_x;
  assign res_y_o     = r_res_y;
  assign res_frame_o = r_res_frame;
  assign drop_cnt_o  = r_drop_cnt;
  assign wd_err_o    = r_wd_err;

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_vsync_d   <= 1'b0;
      r_frame     <= '0;
      r_skip      <= '0;
      r_wd_cnt    <= '0;
      r_acc_clr   <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_x     <= '0;
      r_res_y     <= '0;
      r_res_frame <= '0;
      r_drop_cnt  <= '0;
      r_wd_err    <= 1'b0;
    end else begin
      r_vsync_d <= vsync_i;
      r_acc_clr <= 1'b0;
      if (w_fb) r_frame <= r_frame + 8'd1;
      if (r_res_valid && res_ready_i) r_res_valid <= 1'b0;

      if (w_waiting && !w_fb && !w_wd_hit) r_wd_cnt <= r_wd_cnt + WD_W'(1);
      else                                 r_wd_cnt <= '0;

      if (stop_i) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start_i) begin
              r_state  <= S_ARM;
              r_skip   <= SKIP_W'(SKIP_FRAMES);
              r_wd_err <= 1'b0;
            end
          end
          S_ARM: begin
            if (w_wd_hit) begin
              r_state  <= S_IDLE;
              r_wd_err <= 1'b1;
            end else if (w_fb) begin
              if (r_skip == '0) begin
                r_state   <= S_ACCUM;
                r_acc_clr <= 1'b1;
              end else begin
                r_skip <= r_skip - SKIP_W'(1);
              end
            end
          end
          S_ACCUM: begin
            if (w_wd_hit) begin
              r_state  <= S_IDLE;
              r_wd_err <= 1'b1;
            end else if (w_fb) begin
              r_state <= S_LATCH;
            end
          end
          S_LATCH: begin
            r_res_x     <= bary_x_i;
            r_res_y     <= bary_y_i;
            r_res_frame <= r_frame;
            r_res_valid <= 1'b1;
            // Unconsumed result overwritten: count it, saturating.
            if (r_res_valid && !res_ready_i && (r_drop_cnt != 8'hff))
              r_drop_cnt <= r_drop_cnt + 8'd1;
            if (mode_i) begin
              r_state <= S_IDLE;
            end else begin
              r_state   <= S_ACCUM;
              r_acc_clr <= 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef FRAME_SCHED_OVERLAY_EN
  logic r_sel;

  // Alternates per frame while accumulating; forced low whenever the run is not accumulating.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      r_sel <= 1'b0;
    end else if (stop_i || w_wd_hit || (r_state == S_IDLE) || (r_state == S_ARM) ||
                 ((r_state == S_LATCH) && mode_i)) begin
      r_sel <= 1'b0;
    end else if (w_fb) begin
      r_sel <= ~r_sel;
    end
  end

  assign sel_o = r_sel;
`else
  assign sel_o = 1'b0;
`endif

endmodule

// File: tb/tb_frame_scheduler.sv
// Scoreboard bench for frame_scheduler: a frame-level reference model predicts accepted results,
// drops, clear pulses and enables; a monitor pops expected results on every valid/ready handshake.
module tb_frame_scheduler;

  localparam int SKIP = 1;
  localparam int WD   = 150;
  localparam int XW   = 10;
  localparam int YW   = 9;
  localparam int FL   = 40;

  logic          vga_clk = 1'b0;
  logic          reset;
  logic          vsync_i, img_i, mode_i, start_i, stop_i, res_ready_i;
  logic [XW-1:0] bary_x_i;
  logic [YW-1:0] bary_y_i;
  logic          acc_clr_o, acc_en_o, sel_o, res_valid_o, wd_err_o;
  logic [XW-1:0] res_x_o;
  logic [YW-1:0] res_y_o;
  logic [7:0]    res_frame_o, drop_cnt_o;

  always #20 vga_clk = ~vga_clk;

  frame_scheduler #(
    .SKIP_FRAMES(SKIP), .WD_CYCLES(WD), .X_W(XW), .Y_W(YW)
  ) dut (
    .vga_clk(vga_clk), .reset(reset), .vsync_i(vsync_i), .img_i(img_i), .mode_i(mode_i),
    .start_i(start_i), .stop_i(stop_i), .bary_x_i(bary_x_i), .bary_y_i(bary_y_i),
    .acc_clr_o(acc_clr_o), .acc_en_o(acc_en_o), .sel_o(sel_o), .res_valid_o(res_valid_o),
    .res_ready_i(res_ready_i), .res_x_o(res_x_o), .res_y_o(res_y_o),
    .res_frame_o(res_frame_o), .drop_cnt_o(drop_cnt_o), .wd_err_o(wd_err_o)
  );

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [7:0]    f;
  } res_t;

  res_t exp_q[$];
  res_t pend;
  bit   pend_v = 0;
  int   n_vec = 0, n_err = 0;
  int   n_fall = 0, drops = 0;
  bit   run_active = 0, run_single = 0, exp_wd = 0;
  int   run_k = 0, acc_idx = 0;
  bit   first_cap_seen = 0;
  bit   in_reset = 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every handshake must match the oldest predicted accepted result.
  always @(negedge vga_clk) begin
    if (!in_reset && res_valid_o && res_ready_i) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_result: got x=%0d y=%0d f=%0d, none expected",
                 res_x_o, res_y_o, res_frame_o);
      end else begin
        res_t r;
        r = exp_q.pop_front();
        check("res_x", res_x_o, r.x);
        check("res_y", res_y_o, r.y);
        check("res_frame", res_frame_o, r.f);
      end
    end
  end

  // One video frame: vsync fall at cycle 0, visible area cycles 8..31; optional stop at stop_at.
  task automatic run_frame(input bit rdy, input int stop_at);
    res_t nr;
    bit   cap, accum;
    int   clr_cyc;
    @(posedge vga_clk); #1;
    n_fall++;
    nr.x = XW'($urandom);
    nr.y = YW'($urandom);
    nr.f = 8'(n_fall);
    vsync_i     = 1'b0;
    bary_x_i    = nr.x;
    bary_y_i    = nr.y;
    res_ready_i = rdy;
    if (rdy && pend_v) begin
      exp_q.push_back(pend);
      pend_v = 0;
    end
    clr_cyc = -1;
    cap     = 0;
    if (run_active) begin
      run_k++;
      if (run_k == SKIP + 1) begin
        clr_cyc = 1;
        acc_idx = 0;
      end else if (run_k >= SKIP + 2) begin
        cap = 1;
        if (pend_v) begin
          if (drops < 255) drops++;
          pend = nr;
        end else if (rdy) begin
          exp_q.push_back(nr);
        end else begin
          pend   = nr;
          pend_v = 1;
        end
        if (run_single) run_active = 0;
        else begin
          clr_cyc = 2;
          acc_idx++;
        end
      end
    end
    accum = run_active && (run_k >= SKIP + 1);
    for (int c = 0; c < FL; c++) begin
      if (c > 0) begin
        @(posedge vga_clk); #1;
      end
      if (c == 3) vsync_i = 1'b1;
      img_i  = (c >= 8) && (c < 32);
      stop_i = (c == stop_at);
      if (stop_i) begin
        accum      = 0;
        run_active = 0;
      end
      @(negedge vga_clk);
      check("acc_clr", acc_clr_o, c == clr_cyc);
      check("acc_en", acc_en_o, accum && img_i);
      if (cap && !first_cap_seen && c <= 2) begin
        check("first_valid_latency", res_valid_o, c == 2);
        if (c == 2) first_cap_seen = 1;
      end
      if (c == 20) begin
`ifdef FRAME_SCHED_OVERLAY_EN
        check("sel", sel_o, accum ? (acc_idx % 2) : 0);
`else
        check("sel", sel_o, 0);
`endif
      end
      if (c == FL - 1) begin
        check("drop_cnt", drop_cnt_o, drops);
        check("wd_err", wd_err_o, exp_wd);
      end
    end
    stop_i = 1'b0;
  endtask

  task automatic start_run(input bit m, input bit with_stop);
    @(posedge vga_clk); #1;
    mode_i  = m;
    start_i = 1'b1;
    stop_i  = with_stop;
    @(posedge vga_clk); #1;
    start_i = 1'b0;
    stop_i  = 1'b0;
    if (!with_stop) begin
      run_active = 1;
      run_single = m;
      run_k      = 0;
      exp_wd     = 0;
    end
  endtask

  initial begin
    int nf;
    bit m;
    reset = 1'b1;
    vsync_i = 1'b1; img_i = 0; mode_i = 0; start_i = 0; stop_i = 0; res_ready_i = 0;
    bary_x_i = '0; bary_y_i = '0;
    repeat (3) @(posedge vga_clk);
    #1 reset = 1'b0;
    in_reset = 0;
    @(negedge vga_clk);
    check("rst_acc_clr", acc_clr_o, 0);
    check("rst_acc_en", acc_en_o, 0);
    check("rst_sel", sel_o, 0);
    check("rst_valid", res_valid_o, 0);
    check("rst_x", res_x_o, 0);
    check("rst_y", res_y_o, 0);
    check("rst_frame", res_frame_o, 0);
    check("rst_drop", drop_cnt_o, 0);
    check("rst_wd", wd_err_o, 0);

    // Idle frames: no clears, no enables, no results.
    repeat (2) run_frame(1, -1);

    // Continuous run: ready high, then low for three captures (two drops), then high again.
    start_run(0, 0);
    run_frame(1, -1); run_frame(1, -1); run_frame(1, -1); run_frame(1, -1);
    run_frame(0, -1); run_frame(0, -1); run_frame(0, -1);
    run_frame(1, -1); run_frame(1, -1);
    run_frame(1, 14);
    run_frame(1, -1);

    // start and stop together in IDLE: stop wins.
    start_run(0, 1);
    run_frame(1, -1);

    // Single-shot: exactly one result, then idle.
    start_run(1, 0);
    repeat (SKIP + 4) run_frame($urandom_range(0, 1), -1);

    // Randomized runs.
    repeat (6) begin
      m = $urandom_range(0, 1);
      start_run(m, 0);
      nf = m ? SKIP + 3 : $urandom_range(3, 7);
      for (int f = 0; f < nf; f++)
        run_frame($urandom_range(0, 1), (!m && f == nf - 1) ? $urandom_range(10, 18) : -1);
    end

    // Watchdog: vsync held high after start.
    start_run(0, 0);
    for (int i = 0; i <= WD; i++) begin
      @(negedge vga_clk);
      if (i == WD - 1) check("wd_before", wd_err_o, 0);
      if (i == WD)     check("wd_fire", wd_err_o, 1);
    end
    run_active = 0;
    exp_wd     = 1;
    run_frame(1, -1);
    start_run(1, 0);
    @(negedge vga_clk);
    check("wd_clear_by_start", wd_err_o, 0);
    exp_wd = 0;
    @(posedge vga_clk); #1 stop_i = 1'b1;
    @(posedge vga_clk); #1 stop_i = 1'b0;
    run_active = 0;
    run_frame(0, -1);

    // Drain and final accounting.
    @(posedge vga_clk); #1;
    res_ready_i = 1'b1;
    if (pend_v) begin
      exp_q.push_back(pend);
      pend_v = 0;
    end
    repeat (4) @(negedge vga_clk);
    check("pending_results", exp_q.size(), 0);
    check("final_drop_cnt", drop_cnt_o, drops);
    check("final_valid", res_valid_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
